// File: rtl/ram_port_ctrl_pkg.sv
// ram_port_ctrl_pkg
// Shared definitions for the data-RAM port controller:
//   - state_t            controller FSM states
//   - DEFAULT_DATA_WIDTH default RAM word width (bits)
//   - DEFAULT_ADDR_BITS  default RAM word-address width
//   - FULL_MASK          all-ones byte mask for the default word width
package ram_port_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_BITS  = 9;
    localparam int DEFAULT_MASK_BITS  = DEFAULT_DATA_WIDTH / 8;

    localparam logic [DEFAULT_MASK_BITS-1:0] FULL_MASK = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        CAP     = 3'd2,
        RSP     = 3'd3,
        WR      = 3'd4,
        RMW_RD  = 3'd5,
        RMW_CAP = 3'd6,
        RMW_WR  = 3'd7
    } state_t;

endpackage

// File: rtl/ram_port_controller_merge.sv
// ram_byte_merge
// Combinational byte merge used by read-modify-write stores.
// Ports:
//   old_word    in   DATA_WIDTH  word read back from the RAM
//   new_word    in   DATA_WIDTH  store data
//   mask        in   MASK_BITS   byte select; bit i picks new_word byte i
//   merged_word out  DATA_WIDTH  old_word with the selected bytes replaced
module ram_byte_merge
    import ram_port_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int MASK_BITS  = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] new_word,
    input  logic [MASK_BITS-1:0]  mask,
    output logic [DATA_WIDTH-1:0] merged_word
);

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < MASK_BITS; i++) begin
            if (mask[i]) begin
                merged_word[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_port_controller.sv
// ram_port_controller
// Initiator-side controller for a single-port synchronous data RAM with a
// one-cycle registered read. Accepts one load/store at a time over a
// valid/ready request channel, returns load data over a valid/ready response
// channel. Sub-word stores are done as read-modify-write because the RAM has
// no byte enables.
//
// Build option: define RAM_PORT_CTRL_PARTIAL_WRITE_EN to enable partial
// stores (read-modify-write states and the byte merge). Without it the byte
// mask is ignored and every store writes the full word.
//
// Ports:
//   clock         in   1           rising-edge clock
//   reset         in   1           synchronous, active-high
//   req_valid     in   1           request present
//   req_ready     out  1           high only while idle
//   req_write     in   1           1 = store, 0 = load
//   req_addr      in   ADDR_BITS   word address
//   req_wdata     in   DATA_WIDTH  store data
//   req_bmask     in   MASK_BITS   store byte mask
//   rsp_valid     out  1           load data available
//   rsp_ready     in   1           core accepts load data
//   rsp_rdata     out  DATA_WIDTH  load data, stable while rsp_valid
//   ram_enable    out  1           RAM port enable
//   write_enable  out  1           RAM write enable
//   ram_address   out  ADDR_BITS   RAM word address
//   ram_wdata     out  DATA_WIDTH  RAM write data
//   ram_rdata     in   DATA_WIDTH  RAM registered read data
module ram_port_controller
    import ram_port_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int ADDR_BITS  = DEFAULT_ADDR_BITS,
    localparam int MASK_BITS  = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [MASK_BITS-1:0]  req_bmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_enable,
    output logic                  write_enable,
    output logic [ADDR_BITS-1:0]  ram_address,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    state_t                state;
    state_t                state_next;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  accept;

    assign accept      = req_valid && (state == IDLE);
    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RSP);
    assign rsp_rdata   = rdata_q;
    assign ram_address = addr_q;
    assign ram_wdata   = wdata_q;

`ifdef RAM_PORT_CTRL_PARTIAL_WRITE_EN
    localparam logic [MASK_BITS-1:0] ALL_BYTES = {MASK_BITS{1'b1}};

    logic [MASK_BITS-1:0]  bmask_q;
    logic [DATA_WIDTH-1:0] merged_word;

    // The merge sees the RAM read data during RMW_CAP; the result replaces
    // the latched store data so RMW_WR writes it through ram_wdata.
    ram_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .old_word    (ram_rdata),
        .new_word    (wdata_q),
        .mask        (bmask_q),
        .merged_word (merged_word)
    );
`else
    // Byte mask has no meaning when every store is a full-word write.
    logic unused_bmask;
    assign unused_bmask = ^req_bmask;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RAM_PORT_CTRL_PARTIAL_WRITE_EN
            bmask_q <= '0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
`ifdef RAM_PORT_CTRL_PARTIAL_WRITE_EN
                bmask_q <= req_bmask;
`endif
            end
            if (state == CAP) begin
                rdata_q <= ram_rdata;
            end
`ifdef RAM_PORT_CTRL_PARTIAL_WRITE_EN
            if (state == RMW_CAP) begin
                wdata_q <= merged_word;
            end
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!req_write) begin
                        state_next = RD;
`ifdef RAM_PORT_CTRL_PARTIAL_WRITE_EN
                    end else if (req_bmask == ALL_BYTES) begin
                        state_next = WR;
                    end else if (req_bmask != '0) begin
                        state_next = RMW_RD;
                    end else begin
                        // Empty mask: accepted and retired without touching the RAM.
                        state_next = IDLE;
`else
                    end else begin
                        state_next = WR;
`endif
                    end
                end
            end
            RD:      state_next = CAP;
            CAP:     state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            WR:      state_next = IDLE;
`ifdef RAM_PORT_CTRL_PARTIAL_WRITE_EN
            RMW_RD:  state_next = RMW_CAP;
            RMW_CAP: state_next = RMW_WR;
            RMW_WR:  state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // RAM strobes depend on state alone; the merge cycle (RMW_CAP) is idle on the port.
    always_comb begin
        ram_enable   = 1'b0;
        write_enable = 1'b0;
        case (state)
            RD: begin
                ram_enable = 1'b1;
            end
            WR: begin
                ram_enable   = 1'b1;
                write_enable = 1'b1;
            end
`ifdef RAM_PORT_CTRL_PARTIAL_WRITE_EN
            RMW_RD: begin
                ram_enable = 1'b1;
            end
            RMW_WR: begin
                ram_enable   = 1'b1;
                write_enable = 1'b1;
            end
`endif
            default: begin
                ram_enable   = 1'b0;
                write_enable = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_port_controller.sv
// tb_ram_port_controller
// Bench for ram_port_controller: a behavioural RAM, a transaction-level
// reference (memory image plus the position of the single outstanding
// operation), a per-cycle compare process, and directed plus random stimulus.
// Honours RAM_PORT_CTRL_PARTIAL_WRITE_EN the same way as the design.
module tb_ram_port_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_bmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        ram_enable;
    logic        write_enable;
    logic [8:0]  ram_address;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

`ifdef RAM_PORT_CTRL_PARTIAL_WRITE_EN
    localparam bit PARTIAL_EN = 1'b1;
`else
    localparam bit PARTIAL_EN = 1'b0;
`endif

    always #5 clock = ~clock;

    ram_port_controller dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_bmask    (req_bmask),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .ram_enable   (ram_enable),
        .write_enable (write_enable),
        .ram_address  (ram_address),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int en_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] seed_word(input int a);
        logic [31:0] t;
        t = 32'(a);
        return (t * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // Behavioural RAM: synchronous write, registered read.
    logic [31:0] ram_mem [512];
    bit          ram_loaded = 1'b0;
    always @(posedge clock) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 512; i++) ram_mem[i] <= seed_word(i);
            ram_loaded <= 1'b1;
        end else if (ram_enable) begin
            if (write_enable) ram_mem[ram_address] <= ram_wdata;
            else              ram_rdata <= ram_mem[ram_address];
        end
    end

    // Reference model. op: 0 none, 1 load, 2 full store, 3 partial store.
    // age = number of clock edges since the accepting edge.
    logic [31:0] ref_mem [512];
    bit          ref_loaded = 1'b0;
    bit          live = 1'b0;
    bit          fresh = 1'b0;
    int          op = 0;
    int          age = 0;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_mask;
    logic [31:0] m_exp_rsp;

    always @(posedge clock) begin
        if (!ref_loaded) begin
            for (int i = 0; i < 512; i++) ref_mem[i] <= seed_word(i);
            ref_loaded <= 1'b1;
        end
        if (reset) begin
            op    <= 0;
            age   <= 0;
            live  <= 1'b1;
            fresh <= 1'b1;
        end else if (live) begin
            if (op == 0) begin
                if (req_valid) begin
                    fresh   <= 1'b0;
                    age     <= 0;
                    m_addr  <= req_addr;
                    m_wdata <= req_wdata;
                    m_mask  <= req_bmask;
                    if (!req_write) begin
                        op        <= 1;
                        m_exp_rsp <= ref_mem[req_addr];
                    end else if (PARTIAL_EN && req_bmask == 4'h0) begin
                        op <= 0;
                    end else if (!PARTIAL_EN || req_bmask == 4'hF) begin
                        op <= 2;
                    end else begin
                        op <= 3;
                    end
                end
            end else if (op == 1) begin
                if (age >= 2 && rsp_ready) op <= 0;
                else                       age <= age + 1;
            end else if (op == 2) begin
                ref_mem[m_addr] <= m_wdata;
                op <= 0;
            end else begin
                if (age == 2) begin
                    ref_mem[m_addr] <= merge(ref_mem[m_addr], m_wdata, m_mask);
                    op <= 0;
                end else begin
                    age <= age + 1;
                end
            end
        end
    end

    // Per-cycle compare of every output against the reference.
    always @(negedge clock) begin
        if (live) begin
            logic exp_ready, exp_rv, exp_en, exp_we;
            exp_ready = (op == 0);
            exp_rv    = (op == 1) && (age >= 2);
            exp_en    = ((op == 1 || op == 2) && age == 0) || (op == 3 && (age == 0 || age == 2));
            exp_we    = (op == 2 && age == 0) || (op == 3 && age == 2);
            if (ram_enable) en_cycles++;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check("ram_enable", 32'(ram_enable), 32'(exp_en));
            check("write_enable", 32'(write_enable), 32'(exp_we));
            if (exp_en) check("ram_address", 32'(ram_address), 32'(m_addr));
            if (exp_we)
                check("ram_wdata", ram_wdata,
                      (op == 2) ? m_wdata : merge(ref_mem[m_addr], m_wdata, m_mask));
            if (exp_rv) check("rsp_rdata", rsp_rdata, m_exp_rsp);
            if (fresh && op == 0) begin
                check("reset_rsp_rdata", rsp_rdata, 32'h0);
                check("reset_ram_address", 32'(ram_address), 32'h0);
                check("reset_ram_wdata", ram_wdata, 32'h0);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_bad++;
            $display("FAIL idle_timeout: req_ready still %b after %0d cycles", req_ready, guard);
        end
    endtask

    // Issue one request; for loads, hold rsp_ready low for `stall` cycles once
    // rsp_valid appears, then take the data. lat = cycles from accept to rsp_valid.
    task automatic do_req(input bit wr, input logic [8:0] a, input logic [31:0] d,
                          input logic [3:0] m, input int stall,
                          output logic [31:0] rd, output int lat);
        int guard;
        rd  = 32'h0;
        lat = 0;
        tick();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_bmask = m;
        rsp_ready = 1'b0;
        wait_idle();
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 9'($urandom);
        req_wdata = $urandom;
        req_bmask = 4'($urandom);
        if (!wr) begin
            guard = 0;
            while (!rsp_valid && guard < 50) begin
                tick();
                guard++;
            end
            lat = guard;
            n_cmp++;
            if (guard >= 50) begin
                n_bad++;
                $display("FAIL rsp_timeout: rsp_valid still %b after %0d cycles", rsp_valid, guard);
            end
            repeat (stall) tick();
            rsp_ready = 1'b1;
            rd = rsp_rdata;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          e0;
        int          bad_words;

        // Reset with a request already presented.
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 9'h1FF;
        req_wdata = 32'h1234_5678;
        req_bmask = 4'hF;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        tick();
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_ram_enable", 32'(ram_enable), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        reset = 1'b0;
        tick();
        req_valid = 1'b0;
        check("post_rst_store_wr", 32'(write_enable), 32'h1);
        wait_idle();
        do_req(1'b0, 9'h1FF, 32'h0, 4'h0, 0, rd, lat);
        check("post_rst_load", rd, 32'h1234_5678);

        // Full store then load.
        e0 = en_cycles;
        do_req(1'b1, 9'h005, 32'hDEAD_BEEF, 4'hF, 0, rd, lat);
        wait_idle();
        check("full_store_en_cycles", 32'(en_cycles - e0), 32'd1);
        do_req(1'b0, 9'h005, 32'h0, 4'h0, 0, rd, lat);
        check("load_5_data", rd, 32'hDEAD_BEEF);
        check("load_5_latency", 32'(lat), 32'd2);

        // Partial store over a known word.
        do_req(1'b1, 9'h010, 32'h1122_3344, 4'hF, 0, rd, lat);
        wait_idle();
        e0 = en_cycles;
        do_req(1'b1, 9'h010, 32'h0000_AA00, 4'h2, 0, rd, lat);
        wait_idle();
        check("partial_en_cycles", 32'(en_cycles - e0), PARTIAL_EN ? 32'd2 : 32'd1);
        do_req(1'b0, 9'h010, 32'h0, 4'h0, 0, rd, lat);
        check("partial_load", rd, PARTIAL_EN ? 32'h1122_AA44 : 32'h0000_AA00);

        // Store with empty mask.
        e0 = en_cycles;
        do_req(1'b1, 9'h010, 32'hFFFF_FFFF, 4'h0, 0, rd, lat);
        wait_idle();
        check("zero_mask_en_cycles", 32'(en_cycles - e0), PARTIAL_EN ? 32'd0 : 32'd1);
        do_req(1'b0, 9'h010, 32'h0, 4'h0, 0, rd, lat);
        check("zero_mask_load", rd, PARTIAL_EN ? 32'h1122_AA44 : 32'hFFFF_FFFF);

        // Response back-pressure for 5 cycles.
        do_req(1'b0, 9'h005, 32'h0, 4'h0, 5, rd, lat);
        check("stall_load_data", rd, 32'hDEAD_BEEF);

        // Reset while a partial store sits in its merge cycle.
        do_req(1'b1, 9'h020, 32'hCAFE_F00D, 4'hF, 0, rd, lat);
        wait_idle();
        tick();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 9'h020;
        req_wdata = 32'h0;
        req_bmask = 4'h1;
        wait_idle();
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_write_enable", 32'(write_enable), 32'h0);
        wait_idle();
        do_req(1'b0, 9'h020, 32'h0, 4'h0, 0, rd, lat);
        check("abort_load", rd, PARTIAL_EN ? 32'hCAFE_F00D : 32'h0);

        // Random traffic over a small address window.
        for (int k = 0; k < 300; k++) begin
            logic [8:0]  a;
            logic [3:0]  m;
            bit          wr;
            a  = 9'h040 + 9'($urandom_range(0, 15));
            wr = 1'($urandom_range(0, 1));
            m  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            do_req(wr, a, $urandom, m, $urandom_range(0, 3), rd, lat);
        end
        wait_idle();
        repeat (2) tick();

        bad_words = 0;
        for (int i = 0; i < 512; i++) begin
            if (ram_mem[i] !== ref_mem[i]) bad_words++;
        end
        check("ram_image_bad_words", 32'(bad_words), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
